// File: rtl/pe_pkg.sv
// Shared opcode constants, FSM state type and instruction-class helpers for the
// PE fetch/issue sequencer.
package pe_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_FP     = 7'b1010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_FSTORE = 7'b0100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FLOAD  = 7'b0000111;
    localparam logic [6:0] OP_FMADD  = 7'b1000011;
    localparam logic [6:0] OP_FMSUB  = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB = 7'b1001011;
    localparam logic [6:0] OP_FNMADD = 7'b1001111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_ERR
    } state_t;

    function automatic logic is_r4(input logic [6:0] op);
        return op inside {OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD};
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return is_r4(op) || (op inside {OP_R, OP_FP, OP_JAL, OP_AUIPC, OP_LUI, OP_STORE,
                                        OP_FSTORE, OP_BRANCH, OP_LOAD, OP_IMM, OP_JALR, OP_FLOAD});
    endfunction

    function automatic logic int_wr(input logic [6:0] op);
        return op inside {OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_JAL, OP_AUIPC, OP_LUI};
    endfunction

    function automatic logic fp_wr(input logic [6:0] op);
        return is_r4(op) || (op inside {OP_FP, OP_FLOAD});
    endfunction

    function automatic logic int_rs1(input logic [6:0] op);
        return op inside {OP_R, OP_STORE, OP_FSTORE, OP_BRANCH, OP_LOAD, OP_IMM, OP_JALR, OP_FLOAD};
    endfunction

    function automatic logic int_rs2(input logic [6:0] op);
        return op inside {OP_R, OP_STORE, OP_BRANCH};
    endfunction

    function automatic logic fp_rs1(input logic [6:0] op);
        return is_r4(op) || (op == OP_FP);
    endfunction

    function automatic logic fp_rs2(input logic [6:0] op);
        return is_r4(op) || (op inside {OP_FP, OP_FSTORE});
    endfunction

endpackage

// File: rtl/pe_fetch_issue_ctrl_if.sv
// Bundle of start, instruction-memory, decoder/execute, write-back and redirect
// signals around the fetch/issue sequencer; master is the sequencer side.
interface pe_fetch_issue_ctrl_if;
    logic        start;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_fp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        err;

    modport master (
        input  start, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               wb_valid, wb_rd, wb_fp, redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr, instr, instr_pc, instr_valid, busy, err
    );

    modport slave (
        output start, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
               wb_valid, wb_rd, wb_fp, redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr, instr, instr_pc, instr_valid, busy, err
    );
endinterface

// File: rtl/pe_scoreboard.sv
// Integer/FP register busy bits with issue-time set, write-back clear and a
// read-after-write hazard check on the held instruction's sources.
module pe_scoreboard (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_set,
    input  logic [6:0] i_opcode,
    input  logic [4:0] i_rd,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    input  logic [4:0] i_rs3,
    input  logic       i_wb_valid,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_fp,
    output logic       o_hazard
);
    import pe_pkg::*;

    logic [31:0] r_busy_int, r_busy_fp;
    logic [31:0] w_set_int, w_set_fp, w_clr_int, w_clr_fp;

    always_comb begin
        w_set_int = '0;
        w_set_fp  = '0;
        w_clr_int = '0;
        w_clr_fp  = '0;
        // x0 is hardwired, so it is never marked busy nor cleared
        if (i_set && int_wr(i_opcode) && (i_rd != 5'd0)) w_set_int[i_rd] = 1'b1;
        if (i_set && fp_wr(i_opcode))                    w_set_fp[i_rd]  = 1'b1;
        if (i_wb_valid && !i_wb_fp && (i_wb_rd != 5'd0)) w_clr_int[i_wb_rd] = 1'b1;
        if (i_wb_valid && i_wb_fp)                       w_clr_fp[i_wb_rd]  = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_int <= '0;
            r_busy_fp  <= '0;
        end else begin
            r_busy_int <= (r_busy_int & ~w_clr_int) | w_set_int;
            r_busy_fp  <= (r_busy_fp  & ~w_clr_fp)  | w_set_fp;
        end
    end

    assign o_hazard = (int_rs1(i_opcode) && r_busy_int[i_rs1]) ||
                      (int_rs2(i_opcode) && r_busy_int[i_rs2]) ||
                      (fp_rs1(i_opcode)  && r_busy_fp[i_rs1])  ||
                      (fp_rs2(i_opcode)  && r_busy_fp[i_rs2])  ||
                      (is_r4(i_opcode)   && r_busy_fp[i_rs3]);
endmodule

// File: rtl/pe_fetch_issue_ctrl.sv
// PE fetch/issue sequencer: owns the PC, fetches over valid/ready, holds the word
// for the decoder and issues it when hazard-free. PE_SCOREBOARD_EN adds RAW tracking.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | fetch request presented at pc
// WAIT  | request accepted, waiting for response
// HOLD  | instruction held for decode, issues when hazard-free
// ERR   | illegal opcode fetched, halted until reset
module pe_fetch_issue_ctrl #(
    parameter logic [31:0] RESET_PC = pe_pkg::RESET_PC
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pe_fetch_issue_ctrl_if.master        bus
);
    import pe_pkg::*;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_instr_pc, w_instr_pc_nxt;
    logic        r_drop, w_drop_nxt;
    logic        w_hazard, w_legal, w_instr_valid, w_issue, w_req_hs;

    assign w_legal       = is_legal(r_instr[6:0]);
    assign w_req_hs      = (r_state == ST_REQ) && bus.imem_req_ready;
    assign w_instr_valid = (r_state == ST_HOLD) && w_legal && !w_hazard;
    assign w_issue       = w_instr_valid && bus.instr_ready && !bus.redirect_valid;

`ifdef PE_SCOREBOARD_EN
    pe_scoreboard u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set      (w_issue),
        .i_opcode   (r_instr[6:0]),
        .i_rd       (r_instr[11:7]),
        .i_rs1      (r_instr[19:15]),
        .i_rs2      (r_instr[24:20]),
        .i_rs3      (r_instr[31:27]),
        .i_wb_valid (bus.wb_valid),
        .i_wb_rd    (bus.wb_rd),
        .i_wb_fp    (bus.wb_fp),
        .o_hazard   (w_hazard)
    );
`else
    assign w_hazard = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_drop_nxt     = r_drop;
        unique case (r_state)
            ST_IDLE: if (bus.start) w_state_nxt = ST_REQ;
            ST_REQ: begin
                if (w_req_hs) w_state_nxt = ST_WAIT;
                if (bus.redirect_valid) begin
                    w_pc_nxt = bus.redirect_pc;
                    if (w_req_hs) w_drop_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.redirect_valid) w_pc_nxt = bus.redirect_pc;
                if (bus.imem_rsp_valid) begin
                    w_drop_nxt = 1'b0;
                    // a response that raced a redirect belongs to the stale path
                    if (r_drop || bus.redirect_valid) begin
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_instr_nxt    = bus.imem_rsp_data;
                        w_instr_pc_nxt = r_pc;
                        w_state_nxt    = ST_HOLD;
                    end
                end else if (bus.redirect_valid) begin
                    w_drop_nxt = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!w_legal) begin
                    w_state_nxt = ST_ERR;
                end else if (bus.redirect_valid) begin
                    w_pc_nxt    = bus.redirect_pc;
                    w_state_nxt = ST_REQ;
                end else if (w_issue) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_ERR:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.imem_req_valid = (r_state == ST_REQ);
    assign bus.imem_req_addr  = r_pc;
    assign bus.instr          = r_instr;
    assign bus.instr_pc       = r_instr_pc;
    assign bus.instr_valid    = w_instr_valid;
    assign bus.busy           = (r_state != ST_IDLE) && (r_state != ST_ERR);
    assign bus.err            = (r_state == ST_ERR);
endmodule

// File: tb/tb_pe_fetch_issue_ctrl.sv
// Directed bench for pe_fetch_issue_ctrl; fetched words are queued as expected
// issues and compared when the sequencer issues them. Works with or without PE_SCOREBOARD_EN.
module tb_pe_fetch_issue_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_asserts = 0;
    int   n_fails = 0;
    int   last_issue = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        q_exp[$];
    logic [31:0] m_pc = 32'h0;

    pe_fetch_issue_ctrl_if bus();

    pe_fetch_issue_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_valid"},   32'(bus.imem_req_valid), 32'd0);
        chk({tag, "_req_addr"},    bus.imem_req_addr, 32'h0);
        chk({tag, "_instr"},       bus.instr, 32'h0);
        chk({tag, "_instr_pc"},    bus.instr_pc, 32'h0);
        chk({tag, "_instr_valid"}, 32'(bus.instr_valid), 32'd0);
        chk({tag, "_busy"},        32'(bus.busy), 32'd0);
        chk({tag, "_err"},         32'(bus.err), 32'd0);
    endtask

    // Drive one zero-wait fetch from REQ, leaving the DUT in HOLD.
    task automatic fetch(input logic [31:0] data);
        int n = 0;
        while (bus.imem_req_valid !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        chk("req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("req_addr", bus.imem_req_addr, m_pc);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        chk("wait_no_req", 32'(bus.imem_req_valid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        q_exp.push_back('{pc: m_pc, ins: data});
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
    endtask

    task automatic issue();
        exp_t e;
        chk("issue_valid", 32'(bus.instr_valid), 32'd1);
        chk("q_nonempty", 32'(q_exp.size() != 0), 32'd1);
        if (q_exp.size() != 0) begin
            e = q_exp.pop_front();
            chk("instr", bus.instr, e.ins);
            chk("instr_pc", bus.instr_pc, e.pc);
            m_pc = e.pc + 32'd4;
        end
        last_issue = cyc;
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
    endtask

    initial begin
        int prev;
        bus.start          = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b0;
        bus.wb_valid       = 1'b0;
        bus.wb_rd          = 5'd0;
        bus.wb_fp          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // reset and start, then three back-to-back addi x0 at 0x0/0x4/0x8
        #2;
        chk_reset_vals("rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_no_req", 32'(bus.imem_req_valid), 32'd0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_latency", 32'(bus.imem_req_valid), 32'd1);
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            fetch(32'h0000_0013);
            chk("busy_run", 32'(bus.busy), 32'd1);
            issue();
            if (i > 0) chk("issue_interval", 32'(last_issue - prev), 32'd3);
            prev = last_issue;
        end

        // RAW on x1: addi x1,x0,1 then add x2,x1,x1
        fetch(32'h0010_0093);
        issue();
        fetch(32'h0010_8133);
`ifdef PE_SCOREBOARD_EN
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("raw_stall", 32'(bus.instr_valid), 32'd0);
            chk("hold_stable", bus.instr, 32'h0010_8133);
            tick();
        end
        bus.instr_ready = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd1;
        bus.wb_fp    = 1'b0;
        tick();
        bus.wb_valid = 1'b0;
        chk("wb_release", 32'(bus.instr_valid), 32'd1);
`else
        chk("nosb_valid", 32'(bus.instr_valid), 32'd1);
`endif
        issue();

        // redirect during WAIT: the pending response must be dropped
        chk("rd_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("rd_req_addr", bus.imem_req_addr, m_pc);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        chk("drop_no_req", 32'(bus.imem_req_valid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0050_0093;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk("dropped_no_valid", 32'(bus.instr_valid), 32'd0);
        chk("dropped_instr_kept", bus.instr, 32'h0010_8133);
        chk("dropped_pc_kept", bus.instr_pc, 32'h0000_0010);
        m_pc = 32'h0000_0100;
        fetch(32'h0000_0013);
        issue();

        // fmadd f3 issues in the same cycle a write-back clears f3: set wins
        fetch(32'h0000_01C3);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd3;
        bus.wb_fp    = 1'b1;
        issue();
        bus.wb_valid = 1'b0;
        fetch(32'h0031_8253);
`ifdef PE_SCOREBOARD_EN
        for (int i = 0; i < 2; i++) begin
            chk("fp_set_wins", 32'(bus.instr_valid), 32'd0);
            tick();
        end
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd3;
        bus.wb_fp    = 1'b1;
        tick();
        bus.wb_valid = 1'b0;
        chk("fp_release", 32'(bus.instr_valid), 32'd1);
`else
        chk("nosb_fp_valid", 32'(bus.instr_valid), 32'd1);
`endif
        issue();

        // illegal opcode: sticky err, no further requests
        fetch(32'h0000_007F);
        chk("illegal_no_valid", 32'(bus.instr_valid), 32'd0);
        void'(q_exp.pop_back());
        tick();
        chk("err_set", 32'(bus.err), 32'd1);
        chk("err_not_busy", 32'(bus.busy), 32'd0);
        bus.start          = 1'b1;
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.start = 1'b0;
            chk("err_no_req", 32'(bus.imem_req_valid), 32'd0);
            chk("err_sticky", 32'(bus.err), 32'd1);
        end
        bus.imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("err_rst");
        tick();
        rst_n = 1'b1;
        tick();
        m_pc = 32'h0;

        // redirect in HOLD suppresses issue even with instr_ready high
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        fetch(32'h0010_0293);
        chk("hold_valid", 32'(bus.instr_valid), 32'd1);
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        tick();
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        void'(q_exp.pop_back());
        chk("hredir_no_valid", 32'(bus.instr_valid), 32'd0);
        chk("hredir_req", 32'(bus.imem_req_valid), 32'd1);
        chk("hredir_addr", bus.imem_req_addr, 32'h0000_0200);

        // asynchronous reset while in WAIT, then a late response
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
        chk("wait_busy", 32'(bus.busy), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        rst_n = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0013;
        tick();
        bus.imem_rsp_valid = 1'b0;
        chk_reset_vals("late_rsp");
        m_pc = 32'h0;

        // clean restart after reset
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        fetch(32'h0000_0013);
        issue();
        chk("final_addr", bus.imem_req_addr, 32'h0000_0004);
        chk("queue_empty", 32'(q_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end
endmodule
